apb_master_bridge: RTL

- Upstream APB requester that turns a simple valid/ready command stream into APB3 SETUP/ACCESS transfers toward the APB slave.
- Drives psel/penable/paddr/pwrite/pwdata, waits on pready and returns read data or an error on a valid/ready response channel.
- Bounded wait: an ACCESS phase not completed within TIMEOUT_CYCLES is aborted and reported as an error.
- One outstanding transfer at a time.

---
 rtl/apb_pkg.sv | 40 ++++
 rtl/apb_master_bridge.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
//   Shared definitions for the APB requester and any APB slave placed behind it.
//   - APB_ADDR_W / APB_DATA_W : default bus widths. Slaves should import these
//     so both sides of the bus agree.
//   - APB_TIMEOUT_CYCLES      : default ACCESS-phase wait limit.
//   - apb_mst_state_t         : requester FSM states.
//   - apb_cmd_t               : one command (direction, address, write data) at
//                               the default widths.
//   - apb_cnt_width()         : width of a counter that must reach a given
//                               cycle count, never narrower than 1 bit.
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_ADDR_W         = 10;
  localparam int APB_DATA_W         = 32;
  localparam int APB_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  // clog2(cycles+1) so the counter can represent 0..cycles; a zero-cycle
  // (disabled) timeout still gets a 1-bit counter to keep declarations legal.
  function automatic int apb_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : apb_pkg

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   Converts a valid/ready command stream into APB3 SETUP/ACCESS transfers and
//   returns the outcome on a valid/ready response channel. One transfer is in
//   flight at a time. An ACCESS phase that sees no pready for TIMEOUT_CYCLES
//   cycles is abandoned and reported with rsp_err_o=1 (TIMEOUT_CYCLES=0 waits
//   forever).
//
// Ports
//   clk, reset        : clock (rising edge) / asynchronous active-low reset
//   cmd_valid_i/ready : command handshake; cmd_ready_o is high only in IDLE
//   cmd_write_i       : 1 = write, 0 = read
//   cmd_addr_i        : target address
//   cmd_wdata_i       : write data (ignored for reads)
//   rsp_valid_o/ready : response handshake
//   rsp_rdata_o       : read data; 0 for writes and timed-out transfers
//   rsp_err_o         : 1 = transfer timed out
//   psel_o, penable_o : APB phase qualifiers
//   paddr_o, pwrite_o, pwdata_o : APB address/direction/write data (held after
//                       a transfer; only psel_o/penable_o qualify them)
//   prdata_i, pready_i: APB read data / ready from the slave
//
// Timing: accept -> SETUP (1 cycle) -> ACCESS (>=1 cycle) -> RESP, so a
// zero-wait slave yields rsp_valid_o three cycles after the accept cycle and a
// steady stream runs at one transfer per four cycles.
// -----------------------------------------------------------------------------
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = apb_pkg::APB_ADDR_W,
  parameter int DATA_W         = apb_pkg::APB_DATA_W,
  parameter int TIMEOUT_CYCLES = apb_pkg::APB_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,

  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,

  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  localparam int              CNT_W      = apb_cnt_width(TIMEOUT_CYCLES);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Counter value seen during the last permitted ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST  =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  apb_mst_state_t    state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg,   cnt_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic              pwrite_reg, pwrite_next;
  logic [DATA_W-1:0] pwdata_reg, pwdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg,   err_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      pwdata_reg <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      paddr_reg  <= paddr_next;
      pwrite_reg <= pwrite_next;
      pwdata_reg <= pwdata_next;
      rdata_reg  <= rdata_next;
      err_reg    <= err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    paddr_next  = paddr_reg;
    pwrite_next = pwrite_reg;
    pwdata_next = pwdata_reg;
    rdata_next  = rdata_reg;
    err_next    = err_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid_i) begin
          paddr_next  = cmd_addr_i;
          pwrite_next = cmd_write_i;
          // Reads drive a clean zero rather than whatever sits on the wdata bus.
          pwdata_next = cmd_write_i ? cmd_wdata_i : '0;
          cnt_next    = '0;
          state_next  = SETUP;
        end
      end

      SETUP: begin
        state_next = ACCESS;
      end

      ACCESS: begin
        // pready is tested first so a slave answering in the last allowed
        // cycle still completes successfully.
        if (pready_i) begin
          rdata_next = pwrite_reg ? '0 : prdata_i;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (TIMEOUT_EN && (cnt_reg == CNT_LAST)) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end else if (TIMEOUT_EN) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake and phase outputs decode straight from the state register, so
  // an asynchronous reset drops them without waiting for a clock edge.
  always_comb begin
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    case (state_reg)
      IDLE:    cmd_ready_o = 1'b1;
      SETUP:   psel_o      = 1'b1;
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      RESP:    rsp_valid_o = 1'b1;
      default: cmd_ready_o = 1'b0;
    endcase
  end

  assign paddr_o     = paddr_reg;
  assign pwrite_o    = pwrite_reg;
  assign pwdata_o    = pwdata_reg;
  assign rsp_rdata_o = rdata_reg;
  assign rsp_err_o   = err_reg;

endmodule : apb_master_bridge
